bin_to_bcd_converter: RTL and testbench

//  Sequential double-dabble converter: unsigned binary value (e.g. temperature
//  or counter reading) -> 8-digit packed BCD. Sits directly upstream of the

---
 rtl/bin_to_bcd_converter.sv | 179 +++++++++++++++++
 tb/tb_bin_to_bcd_converter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_converter
//
// Purpose: sequential double-dabble converter. It turns an unsigned binary
// value into 8 packed BCD digits, one bit per clock. It is meant to feed a
// seven-segment display block directly: bcd_out drives the display's wr_data
// and done drives its wr_en.
//
// Handshake:
//   start is sampled only while idle (busy=0). The edge that samples start=1
//   also captures bin_in. busy then stays high until the FSM is back in IDLE.
//   done is a single-cycle pulse, asserted BIN_WIDTH cycles after the
//   accepting edge. bcd_out, overflow and blank_mask update in the same cycle
//   and hold until the next done pulse. A start seen while busy is dropped;
//   it is not queued.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to build the leading-zero
//   blank mask. When the macro is undefined, blank_mask is a constant 0.
//
// Parameters:
//   BIN_WIDTH  width of bin_in, 1..27 (27 bits reach 99_999_999)
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   start      in   conversion request
//   bin_in     in   unsigned value to convert
//   busy       out  FSM is not idle
//   done       out  one-cycle result-valid pulse
//   bcd_out    out  packed BCD: digit 7 in [31:28] ... digit 0 in [3:0]
//   overflow   out  last captured value was above 99_999_999
//   blank_mask out  bit i = digit i is a leading zero
//   state_dbg  out  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module bin_to_bcd_converter #(
  parameter int BIN_WIDTH = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          bcd_out,
  output logic                 overflow,
  output logic [7:0]           blank_mask,
  output logic [1:0]           state_dbg
);

  localparam int CNT_W = (BIN_WIDTH < 2) ? 1 : $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [31:0]          r_scratch;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf_pending;
  logic [31:0]          r_bcd_out;
  logic                 r_overflow;

  logic [31:0]          w_adj;
  logic [31:0]          w_shift_bcd;
  logic                 w_last;
  logic [26:0]          w_bin_ext;
  logic                 w_ovf_in;

  // Zero-extending to 27 bits makes the compare constant-false for narrower
  // inputs, so the overflow path disappears when it cannot trigger.
  assign w_bin_ext = 27'(bin_in);
  assign w_ovf_in  = (w_bin_ext > 27'd99_999_999);

  assign w_last = (r_cnt == CNT_W'(BIN_WIDTH - 1));

  // Add 3 to every nibble >= 5. Each nibble is handled on its own, with no
  // carry between nibbles, before the whole vector shifts.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < 8; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      else                             w_adj[4*i +: 4] = r_scratch[4*i +: 4];
    end
  end

  assign w_shift_bcd = {w_adj[30:0], r_bin[BIN_WIDTH-1]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin         <= '0;
      r_scratch     <= '0;
      r_cnt         <= '0;
      r_ovf_pending <= 1'b0;
      r_bcd_out     <= '0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin         <= bin_in;
            r_scratch     <= '0;
            r_cnt         <= '0;
            r_ovf_pending <= w_ovf_in;
          end
        end
        SHIFT: begin
          r_scratch <= w_shift_bcd;
          r_bin     <= r_bin << 1;
          r_cnt     <= r_cnt + 1'b1;
          if (w_last) begin
            // The scratch register is not a valid result on overflow, so it is
            // replaced by the saturated all-nines pattern.
            r_bcd_out  <= r_ovf_pending ? 32'h9999_9999 : w_shift_bcd;
            r_overflow <= r_ovf_pending;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] r_blank;
  logic [7:0] w_mask;

  // Bit i is set when digits 7..i are all zero. Bit 0 is never set, so a
  // value of zero still shows a single '0'.
  always_comb begin
    logic v_zero;
    v_zero = 1'b1;
    w_mask = '0;
    for (int i = 7; i >= 1; i--) begin
      v_zero    = v_zero & (w_shift_bcd[4*i +: 4] == 4'd0);
      w_mask[i] = v_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blank <= '0;
    end else if (r_state == SHIFT && w_last) begin
      r_blank <= r_ovf_pending ? 8'h00 : w_mask;
    end
  end

  assign blank_mask = r_blank;
`else
  assign blank_mask = 8'h00;
`endif

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign bcd_out   = r_bcd_out;
  assign overflow  = r_overflow;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
module tb_bin_to_bcd_converter;
  localparam int BW  = 27;
  localparam int LAT = BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BW-1:0] bin_in;
  logic          busy;
  logic          done;
  logic [31:0]   bcd_out;
  logic          overflow;
  logic [7:0]    blank_mask;
  logic [1:0]    state_dbg;

  bin_to_bcd_converter #(.BIN_WIDTH(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .overflow   (overflow),
    .blank_mask (blank_mask),
    .state_dbg  (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  int          checks   = 0;
  int          fails    = 0;
  int          done_cnt = 0;
  logic [40:0] exp_q[$];   // {overflow, blank_mask, bcd_out}
  logic [40:0] mon_e;
  logic [31:0] last_bcd;

  typedef struct {
    logic [BW-1:0] bin;
    logic [31:0]   bcd;
    logic          ovf;
    logic [7:0]    mask_en;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sel_mask(input logic [7:0] m);
`ifdef LEADING_ZERO_BLANK_EN
    return m;
`else
    return 8'h00;
`endif
  endfunction

  // reference model: decimal digits by division
  function automatic logic [31:0] model_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    if (v > 99_999_999) return 32'h9999_9999;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_mask(input logic [31:0] b, input logic ovf);
    logic [7:0] m;
    logic z;
    m = '0;
    z = 1'b1;
    if (ovf) return 8'h00;
    for (int i = 7; i >= 1; i--) begin
      z = z & (b[4*i +: 4] == 4'd0);
      m[i] = z;
    end
    return m;
  endfunction

  // scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_e = exp_q.pop_front();
        check("bcd_out", bcd_out, mon_e[31:0]);
        check("overflow", 32'(overflow), 32'(mon_e[40]));
        check("blank_mask", 32'(blank_mask), 32'(mon_e[39:32]));
      end
    end
  end

  // one conversion with latency and busy checks; result checked by scoreboard
  task automatic run_one(input logic [BW-1:0] v, input logic [31:0] eb, input logic eo, input logic [7:0] em);
    int n;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    exp_q.push_back({eo, em, eb});
    @(negedge clk);
    start  = 1'b0;
    bin_in = BW'($urandom_range(0, 2**BW - 1));
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      if (done === 1'b1) begin n = i - 1; break; end
      @(negedge clk);
      if (i == 100) n = -1;
    end
    check("latency", n, LAT);
    check("state_done", 32'(state_dbg), 32'd2);
    last_bcd = eb;
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int           dc0;
    int unsigned  rv;
    logic [31:0]  mb;
    logic         mo;

    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", bcd_out, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_mask", 32'(blank_mask), 32'd0);
    rst = 1'b0;

    vecs[0] = '{bin: 27'd25,          bcd: 32'h0000_0025, ovf: 1'b0, mask_en: 8'b1111_1100};
    vecs[1] = '{bin: 27'd12_345_678,  bcd: 32'h1234_5678, ovf: 1'b0, mask_en: 8'h00};
    vecs[2] = '{bin: 27'd0,           bcd: 32'h0000_0000, ovf: 1'b0, mask_en: 8'b1111_1110};
    vecs[3] = '{bin: 27'd99_999_999,  bcd: 32'h9999_9999, ovf: 1'b0, mask_en: 8'h00};
    vecs[4] = '{bin: 27'd100_000_000, bcd: 32'h9999_9999, ovf: 1'b1, mask_en: 8'h00};
    vecs[5] = '{bin: 27'd134_217_727, bcd: 32'h9999_9999, ovf: 1'b1, mask_en: 8'h00};
    vecs[6] = '{bin: 27'd1,           bcd: 32'h0000_0001, ovf: 1'b0, mask_en: 8'b1111_1110};
    vecs[7] = '{bin: 27'd10,          bcd: 32'h0000_0010, ovf: 1'b0, mask_en: 8'b1111_1100};
    vecs[8] = '{bin: 27'd90_000_000,  bcd: 32'h9000_0000, ovf: 1'b0, mask_en: 8'h00};
    vecs[9] = '{bin: 27'd10_000_001,  bcd: 32'h1000_0001, ovf: 1'b0, mask_en: 8'h00};

    for (int k = 0; k < 10; k++)
      run_one(vecs[k].bin, vecs[k].bcd, vecs[k].ovf, sel_mask(vecs[k].mask_en));

    // random values against the division model
    for (int k = 0; k < 8; k++) begin
      rv = $urandom_range(0, 2**BW - 1);
      mb = model_bcd(rv);
      mo = (rv > 99_999_999);
      run_one(BW'(rv), mb, mo, sel_mask(model_mask(mb, mo)));
    end

    // outputs hold between done pulses while inputs wander
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bin_in = BW'($urandom_range(0, 2**BW - 1));
    end
    check("hold_bcd", bcd_out, last_bcd);

    // start held high, bin_in changing every cycle: accepts every BW+2 cycles
    dc0 = done_cnt;
    for (int n = 0; n < 3 * (BW + 2); n++) begin
      @(negedge clk);
      start = 1'b1;
      rv = $urandom_range(0, 2**BW - 1);
      bin_in = BW'(rv);
      if (n % (BW + 2) == 0) begin
        mb = model_bcd(rv);
        mo = (rv > 99_999_999);
        exp_q.push_back({mo, sel_mask(model_mask(mb, mo)), mb});
      end
      @(posedge clk);
      #1;
      check("held_busy", 32'(busy), 32'((n % (BW + 2)) != (BW + 1)));
      if ((n % (BW + 2)) == BW) check("held_done", 32'(done), 32'd1);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("held_done_count", done_cnt - dc0, 3);

    // reset during the 10th shift cycle aborts with no done
    @(negedge clk);
    start  = 1'b1;
    bin_in = 27'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    dc0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", bcd_out, 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    repeat (BW + 5) @(negedge clk);
    check("abort_no_done", done_cnt - dc0, 0);

    // normal conversion after the abort
    run_one(27'd25, 32'h0000_0025, 1'b0, sel_mask(8'b1111_1100));
    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
